// File: rtl/fp_pkg.sv
// Shared definitions for the binary64 adder back end: field widths,
// rounding-mode encoding, pipeline stage records and rounding helpers.
package fp_pkg;

  localparam int EXP_W   = 11;
  localparam int FRAC_W  = 52;
  localparam int MANT_W  = FRAC_W + 1;   // mantissa with hidden bit
  localparam int SUM_W   = MANT_W + 4;   // carry bit + mantissa + G/R/S
  localparam int NORM_W  = SUM_W - 1;    // normalized mantissa + G/R/S
  localparam int EXPI_W  = EXP_W + 2;    // internal exponent, room for carries
  localparam int BIAS    = 1023;
  localparam int EXP_MAX = 2 * BIAS + 1; // all-ones exponent field

  localparam logic [EXPI_W-1:0] EXP_ONE  = EXPI_W'(1);
  localparam logic [EXPI_W-1:0] EXP_INF  = EXPI_W'(EXP_MAX);

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } rm_e;

  // Add stage: raw 57-bit sum with the larger operand's exponent.
  typedef struct packed {
    logic              valid;
    logic              sign;
    logic [EXPI_W-1:0] exp;
    logic [SUM_W-1:0]  sum;
    rm_e               rm;
  } add_stage_t;

  // Normalize stage: mantissa with hidden bit, separate G/R/S.
  typedef struct packed {
    logic              valid;
    logic              sign;
    logic              zero;
    logic [EXPI_W-1:0] exp;
    logic [MANT_W-1:0] mant;
    logic [2:0]        grs;
    rm_e               rm;
  } stage_t;

  // Decide whether the kept mantissa is incremented.
  function automatic logic round_inc(input rm_e rm, input logic sign,
                                     input logic lsb, input logic g,
                                     input logic rs);
    logic inc;
    case (rm)
      RM_RNE:  inc = g & (rs | lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = ~sign & (g | rs);
      RM_RDN:  inc = sign & (g | rs);
      default: inc = g & (rs | lsb);
    endcase
    return inc;
  endfunction

  // On overflow, decide whether the result saturates to max finite.
  function automatic logic ovf_to_max(input rm_e rm, input logic sign);
    logic sat;
    case (rm)
      RM_RNE:  sat = 1'b0;
      RM_RTZ:  sat = 1'b1;
      RM_RUP:  sat = sign;
      RM_RDN:  sat = ~sign;
      default: sat = 1'b0;
    endcase
    return sat;
  endfunction

endpackage

// File: rtl/fadd_norm_round_lzc56.sv
// Combinational 56-bit leading-zero counter; an all-zero input reports 56.
module lzc56 (
  input  logic [55:0] vec,
  output logic [5:0]  cnt
);

  // Scan low to high so the highest set bit determines the count.
  always_comb begin
    cnt = 6'd56;
    for (int i = 0; i < 56; i++) begin
      cnt = vec[i] ? 6'(55 - i) : cnt;
    end
  end

endmodule

// File: rtl/fadd_norm_round.sv
// Back end of the binary64 adder: effective add/subtract, normalize
// (including gradual underflow), round and pack, as a 3-stage elastic
// pipeline with a single global stall.
// Optional feature macro: FADD_ROUND_MODES_EN adds the rm[1:0] input
// (RNE/RTZ/RUP/RDN); without it the block rounds to nearest-even only.
module fadd_norm_round
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign_res,
  input  logic              eff_sub,
  input  logic [EXP_W-1:0]  exp_large,
  input  logic [MANT_W-1:0] mant_large,
  input  logic [MANT_W-1:0] mant_small,
  input  logic              g_in,
  input  logic              r_in,
  input  logic              s_in,
`ifdef FADD_ROUND_MODES_EN
  input  logic [1:0]        rm,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       result,
  output logic              overflow,
  output logic              inexact
);

  logic advance;
  rm_e  rm_in;

  add_stage_t s1_d, s1_q;
  stage_t     s2_d, s2_q;

  logic        out_valid_q;
  logic [63:0] result_d, result_q;
  logic        overflow_d, overflow_q;
  logic        inexact_d, inexact_q;

`ifdef FADD_ROUND_MODES_EN
  assign rm_in = rm_e'(rm);
`else
  assign rm_in = RM_RNE;
`endif

  // The whole pipe moves together whenever the output slot is free.
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  // ---------------------------------------------------------------- S1
  logic [SUM_W-1:0] op_a, op_b;

  // Effective add or subtract of the aligned mantissas.
  always_comb begin
    s1_d       = '0;
    op_a       = {1'b0, mant_large, 3'b000};
    op_b       = {1'b0, mant_small, g_in, r_in, s_in};
    s1_d.valid = in_valid;
    s1_d.sign  = sign_res;
    s1_d.exp   = {2'b00, exp_large};
    s1_d.rm    = rm_in;
    if (eff_sub) begin
      s1_d.sum = op_a - op_b;
    end else begin
      s1_d.sum = op_a + op_b;
    end
  end

  // Stage 1 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
    end else if (advance) begin
      s1_q <= s1_d;
    end
  end

  // ---------------------------------------------------------------- S2
  logic [5:0]        lz;
  logic [5:0]        shamt;
  logic [EXPI_W-1:0] cap;
  logic [EXPI_W-1:0] exp_n;
  logic [EXPI_W-1:0] exp_adj;
  logic [NORM_W-1:0] norm;

  lzc56 u_lzc (
    .vec (s1_q.sum[NORM_W-1:0]),
    .cnt (lz)
  );

  // Normalize: absorb a carry-out, or shift left but never below exp 1.
  always_comb begin
    norm  = '0;
    exp_n = s1_q.exp;
    cap   = '0;
    shamt = 6'd0;
    if (s1_q.sum[SUM_W-1]) begin
      norm  = {s1_q.sum[SUM_W-1:2], s1_q.sum[1] | s1_q.sum[0]};
      exp_n = s1_q.exp + EXP_ONE;
    end else begin
      cap   = (s1_q.exp > EXP_ONE) ? (s1_q.exp - EXP_ONE) : '0;
      shamt = (EXPI_W'(lz) < cap) ? lz : cap[5:0];
      norm  = s1_q.sum[NORM_W-1:0] << shamt;
      exp_n = s1_q.exp - EXPI_W'(shamt);
    end
    // Missing hidden bit after the capped shift means a subnormal result.
    exp_adj = norm[NORM_W-1] ? exp_n : '0;

    s2_d       = '0;
    s2_d.valid = s1_q.valid;
    s2_d.sign  = s1_q.sign;
    s2_d.zero  = (s1_q.sum == '0);
    s2_d.exp   = exp_adj;
    s2_d.mant  = norm[NORM_W-1:3];
    s2_d.grs   = norm[2:0];
    s2_d.rm    = s1_q.rm;
  end

  // Stage 2 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_q <= '0;
    end else if (advance) begin
      s2_q <= s2_d;
    end
  end

  // ---------------------------------------------------------------- S3
  logic              g_b, rs_b, rnd_up;
  logic [MANT_W:0]   mant_r;
  logic [EXPI_W-1:0] exp_r;
  logic [FRAC_W-1:0] frac;

  // Round, renormalize on carry, detect overflow and pack.
  always_comb begin
    g_b    = s2_q.grs[2];
    rs_b   = s2_q.grs[1] | s2_q.grs[0];
    rnd_up = round_inc(s2_q.rm, s2_q.sign, s2_q.mant[0], g_b, rs_b);
    mant_r = {1'b0, s2_q.mant} + {{MANT_W{1'b0}}, rnd_up};

    if (mant_r[MANT_W]) begin
      exp_r = s2_q.exp + EXP_ONE;
      frac  = mant_r[FRAC_W:1];
    end else if ((s2_q.exp == '0) && mant_r[FRAC_W]) begin
      exp_r = EXP_ONE;
      frac  = mant_r[FRAC_W-1:0];
    end else begin
      exp_r = s2_q.exp;
      frac  = mant_r[FRAC_W-1:0];
    end

    if (s2_q.zero) begin
      result_d   = {(s2_q.rm == RM_RDN), 63'd0};
      overflow_d = 1'b0;
      inexact_d  = 1'b0;
    end else if (exp_r >= EXP_INF) begin
      overflow_d = 1'b1;
      inexact_d  = 1'b1;
      if (ovf_to_max(s2_q.rm, s2_q.sign)) begin
        result_d = {s2_q.sign, EXP_W'(EXP_MAX - 1), {FRAC_W{1'b1}}};
      end else begin
        result_d = {s2_q.sign, EXP_W'(EXP_MAX), {FRAC_W{1'b0}}};
      end
    end else begin
      result_d   = {s2_q.sign, exp_r[EXP_W-1:0], frac};
      overflow_d = 1'b0;
      inexact_d  = g_b | rs_b;
    end
  end

  // Output register; holds result and flags while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= 64'd0;
      overflow_q  <= 1'b0;
      inexact_q   <= 1'b0;
    end else if (advance) begin
      out_valid_q <= s2_q.valid;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      inexact_q   <= inexact_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign inexact   = inexact_q;

endmodule

// File: tb/tb_fadd_norm_round.sv
// Self-checking bench for fadd_norm_round: directed cases, randomized
// stream with backpressure against a value-level reference model, reset.
module tb_fadd_norm_round;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, sign_res, eff_sub;
  logic        g_in, r_in, s_in, out_valid, out_ready, overflow, inexact;
  logic [10:0] exp_large;
  logic [52:0] mant_large, mant_small;
  logic [63:0] result;
`ifdef FADD_ROUND_MODES_EN
  logic [1:0]  rm = 2'b00;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_out   = 0;
  logic [65:0] exp_q[$];
  logic        hold_pend  = 1'b0;
  logic [65:0] hold_val   = '0;
  logic        last_acc   = 1'b0;
  logic        stall_seen = 1'b0;

  always #5 clk = ~clk;

  fadd_norm_round dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sign_res   (sign_res),
    .eff_sub    (eff_sub),
    .exp_large  (exp_large),
    .mant_large (mant_large),
    .mant_small (mant_small),
    .g_in       (g_in),
    .r_in       (r_in),
    .s_in       (s_in),
`ifdef FADD_ROUND_MODES_EN
    .rm         (rm),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .overflow   (overflow),
    .inexact    (inexact)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=0x%h want=0x%h", tag, got, want);
    end
  endtask

  // Value-level model: exact integer sum, pick the result quantum from the
  // magnitude, divide with remainder, round to nearest-even, then pack.
  function automatic void ref_model(input logic [10:0] e, input logic [52:0] ml,
                                    input logic [55:0] sm, input logic sub,
                                    input logic sgn, output logic [63:0] res,
                                    output logic ovf, output logic inx);
    logic [63:0] a, b, s, m, rem, half;
    int p, ee, eb, k;
    a = {8'd0, ml, 3'b000};
    b = {8'd0, sm};
    s = sub ? a - b : a + b;
    ovf = 1'b0;
    inx = 1'b0;
    if (s == 64'd0) begin
      res = 64'd0;
      return;
    end
    p = 0;
    for (int i = 0; i < 64; i++) if (s[i]) p = i;
    // s is in units of 2^(e-BIAS-55); leading bit sits at 2^(p+e-BIAS-55).
    ee = p + int'(e) - 55;
    eb = (ee < 1) ? 1 : ee;
    k  = eb - int'(e) + 3;
    if (k > 0) begin
      m    = s >> k;
      rem  = s & ((64'd1 << k) - 64'd1);
      half = 64'd1 << (k - 1);
      inx  = (rem != 64'd0);
      if (rem > half || (rem == half && m[0])) m = m + 64'd1;
    end else begin
      m = s << (-k);
    end
    if (ee < 1) ee = 0;
    if (m == (64'd1 << 53)) begin
      m  = m >> 1;
      ee = ee + 1;
    end
    if (ee == 0 && m[52]) ee = 1;
    if (ee >= EXP_MAX) begin
      res = {sgn, 11'h7FF, 52'd0};
      ovf = 1'b1;
      inx = 1'b1;
    end else begin
      res = {sgn, 11'(ee), m[51:0]};
    end
  endfunction

  // One clock: sample handshakes just after the drive point, then wait.
  task automatic step();
    logic [63:0] r;
    logic        o, x;
    logic [65:0] e;
    #1;
    if (hold_pend) begin
      check("hold_result", result, hold_val[65:2]);
      check("hold_flags", {62'd0, overflow, inexact}, {62'd0, hold_val[1:0]});
    end
    if (in_valid && !in_ready) stall_seen = 1'b1;
    if (in_valid && in_ready && !rst) begin
      ref_model(exp_large, mant_large, {mant_small, g_in, r_in, s_in}, eff_sub, sign_res, r, o, x);
      exp_q.push_back({r, o, x});
    end
    if (out_valid && out_ready) begin
      n_out++;
      check("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("result", result, e[65:2]);
        check("flags", {62'd0, overflow, inexact}, {62'd0, e[1:0]});
      end
    end
    hold_pend = out_valid && !out_ready && !rst;
    hold_val  = {result, overflow, inexact};
    last_acc  = in_valid && in_ready && !rst;
    @(negedge clk);
  endtask

  task automatic rand_beat();
    logic [63:0] r64;
    logic [55:0] big, sm;
    case ($urandom_range(0, 3))
      0:       exp_large = 11'd1;
      1:       exp_large = 11'h7FE;
      2:       exp_large = 11'($urandom_range(1, 2046));
      default: exp_large = 11'($urandom_range(2, 60));
    endcase
    r64 = {$urandom(), $urandom()};
    mant_large = {1'b1, r64[51:0]};
    if (exp_large == 11'd1 && $urandom_range(0, 1) == 1) mant_large[52] = 1'b0;
    big = {mant_large, 3'b000};
    r64 = {$urandom(), $urandom()};
    case ($urandom_range(0, 3))
      0, 1: begin
        sm = r64[55:0] >> $urandom_range(0, 56);
        if (sm > big) sm = 56'(64'(sm) % (64'(big) + 64'd1));
      end
      2:       sm = (big > {48'd0, r64[7:0]}) ? big - {48'd0, r64[7:0]} : 56'd0;
      default: sm = big;
    endcase
    {mant_small, g_in, r_in, s_in} = sm;
    sign_res = 1'($urandom_range(0, 1));
    eff_sub  = 1'($urandom_range(0, 1));
  endtask

  task automatic directed(input string tag, input logic [10:0] e, input logic [52:0] ml,
                          input logic [52:0] ms, input logic [2:0] grs, input logic sub,
                          input logic [63:0] want, input logic wo, input logic wx);
    int lat;
    exp_large  = e;
    mant_large = ml;
    mant_small = ms;
    {g_in, r_in, s_in} = grs;
    eff_sub    = sub;
    sign_res   = 1'b0;
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd3);
    check({tag, "_result"}, result, want);
    check({tag, "_overflow"}, {63'd0, overflow}, {63'd0, wo});
    check({tag, "_inexact"}, {63'd0, inexact}, {63'd0, wx});
    step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, n0, stale;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sign_res = 1'b0; eff_sub = 1'b0;
    exp_large = '0; mant_large = '0; mant_small = '0; g_in = 1'b0; r_in = 1'b0; s_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    check("rst_inexact", {63'd0, inexact}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst = 1'b0;
    @(negedge clk);

    directed("one_plus_one", 11'h3FF, 53'h10000000000000, 53'h10000000000000, 3'b000, 1'b0,
             64'h4000000000000000, 1'b0, 1'b0);
    directed("one_minus_one", 11'h3FF, 53'h10000000000000, 53'h10000000000000, 3'b000, 1'b1,
             64'h0000000000000000, 1'b0, 1'b0);
    directed("tie_even", 11'h3FF, 53'h10000000000000, 53'h0, 3'b100, 1'b0,
             64'h3FF0000000000000, 1'b0, 1'b1);
    directed("tie_odd", 11'h3FF, 53'h10000000000001, 53'h0, 3'b100, 1'b0,
             64'h3FF0000000000002, 1'b0, 1'b1);
    directed("overflow", 11'h7FE, 53'h1FFFFFFFFFFFFF, 53'h1FFFFFFFFFFFFF, 3'b000, 1'b0,
             64'h7FF0000000000000, 1'b1, 1'b1);
    directed("underflow", 11'h001, 53'h10000000000000, 53'h0FFFFFFFFFFFFF, 3'b000, 1'b1,
             64'h0000000000000001, 1'b0, 1'b0);

    // Six beats against a five-cycle output stall.
    n0 = n_out; sent = 0; stall_seen = 1'b0; last_acc = 1'b1;
    for (int c = 0; c < 40 && (sent < 6 || exp_q.size() != 0); c++) begin
      out_ready = (c >= 5);
      if (sent < 6 && last_acc) rand_beat();
      in_valid = (sent < 6);
      step();
      if (last_acc) sent++;
    end
    in_valid = 1'b0;
    check("bp_in_ready_dropped", {63'd0, stall_seen}, 64'd1);
    check("bp_beats_out", 64'(n_out - n0), 64'd6);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Randomized stream with random backpressure.
    last_acc = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (last_acc || !in_valid) begin
        in_valid = ($urandom_range(0, 9) < 7);
        rand_beat();
      end
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    check("rand_drained", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a stream discards in-flight beats.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    repeat (4) begin
      rand_beat();
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    exp_q.delete();
    hold_pend = 1'b0;
    rst = 1'b0;
    stale = 0;
    repeat (10) begin
      step();
      if (out_valid) stale++;
    end
    check("midrst_no_stale", 64'(stale), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fadd_norm_round.md
Name: fadd_norm_round

Overview:
Downstream stage of the FP adder alignment shifter. Consumes the larger operand's mantissa and exponent, plus the right-shifted smaller mantissa with its G/R/S bits. Performs the effective add or subtract, normalizes the sum (including underflow to subnormal), rounds, and packs an IEEE-754 binary64 result. It is a 3-stage elastic pipeline with valid/ready on both sides.

Parameters:
EXP_W, 11, exponent field width
FRAC_W, 52, stored fraction width (mantissa = FRAC_W+1)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  stage accepts input this cycle
sign_res  in  1  sign of larger-magnitude operand
eff_sub  in  1  1 = effective subtraction
exp_large  in  EXP_W  biased exponent of larger operand (subnormal presented as 1)
mant_large  in  FRAC_W+1  larger mantissa, hidden bit included
mant_small  in  FRAC_W+1  aligned smaller mantissa
g_in  in  1  guard bit of mant_small
r_in  in  1  round bit of mant_small
s_in  in  1  sticky bit of mant_small
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  64  packed binary64 result
overflow  out  1  result rounded to infinity
inexact  out  1  any nonzero bits discarded

Behaviour:
- Reset: all stage valids = 0, out_valid = 0, result = 0, overflow = 0, inexact = 0. The reset also discards in-flight beats; no beat emerges after reset.
- Global stall: advance = !out_valid || out_ready. in_ready = advance. All stage registers load only when advance = 1.
- Latency: 3 cycles from accepted input to out_valid when there is no stall. Throughput is 1 per cycle. Order is preserved.
- Upstream contract: operands are finite; mant_large ≥ {mant_small,g,r,s} in magnitude.
- S1 (add):
  - A = {0, mant_large, 000}; B = {0, mant_small, g, r, s}; both 57 bits.
  - sum = eff_sub ? A−B : A+B.
- S2 (normalize):
  - If sum[56] = 1: shift right 1, OR the dropped bit into sticky, exp+1.
  - Otherwise: lz = leading zeros of sum[55:0]. Shift left by min(lz, exp−1) and subtract that amount from exp.
  - If the hidden bit is still 0 afterwards, the result is subnormal (exp field 0).
  - If sum = 0: result +0 (RNE), flags 0.
- S3 (round/pack):
  - Round to nearest, ties to even, on LSB/G/(R|S). inexact = G|R|S.
  - Rounding carry renormalizes (exp+1). A subnormal that rounds up to the hidden bit becomes exp 1.
  - exp ≥ 2^EXP_W−1 → ±infinity (exp all-ones, fraction 0), overflow = 1, inexact = 1.
- Simultaneous in_valid and stall: the beat is not accepted; upstream holds it.
- Flags are valid only while out_valid = 1 and held stable under stall.

Optional Feature:
FADD_ROUND_MODES_EN
- Defined: adds input rm[1:0], captured with the beat and pipelined alongside it.
  - 00 RNE, 01 RTZ, 10 RUP, 11 RDN.
  - Overflow under RTZ, or under the directed mode opposite to the sign, gives the max finite value with overflow = 1.
  - Exact zero difference is −0 under RDN.
- Undefined: rm port absent; RNE only.

Decomposition:
- Shared package fp_pkg: EXP_W, FRAC_W, BIAS = 1023, EXP_MAX, round-mode enum, and the stage-register struct (sign, exp, mant, grs, valid).
- One sub-module, lzc56: a combinational 56-bit leading-zero counter returning 6 bits, used in S2.

Test Plan:
- 1.0+1.0: exp_large = 0x3FF, both mants = 0x10000000000000, grs = 000, eff_sub = 0 → result 0x4000000000000000 exactly 3 cycles later; flags 0.
- 1.0−1.0 (same operands, eff_sub = 1) → result 0x0000000000000000; overflow = 0, inexact = 0.
- Tie rounding: mant_large = 0x10000000000000, mant_small = 0, g = 1, r = s = 0 → 0x3FF0000000000000, inexact = 1. Same with mant_large LSB = 1 → fraction rounds up to 0x0000000000002, no tie-to-odd.
- Overflow: exp_large = 0x7FE, both mants = 0x1FFFFFFFFFFFFF, add → 0x7FF0000000000000; overflow = 1, inexact = 1.
- Underflow: exp_large = 1, mant_large = 0x10000000000000, mant_small = 0x0FFFFFFFFFFFFF, sub → subnormal result 0x0000000000000001, exp field 0.
- Backpressure/reset:
  - Stream 6 beats with out_ready low for 5 cycles → in_ready drops, no beat lost or duplicated, order kept.
  - Assert rst mid-stream → out_valid = 0 next cycle; no stale beats emerge after reset release.
